// File: rtl/clint_pkg.sv
// clint_pkg: constants shared by the CLINT register core and its AXI front end.
//   - Register offsets decoded by clint_axi2reg.
//   - Reset value of mtimecmp (all ones, so no timer interrupt after reset).
//   - presc_width(): prescaler counter width for a given tick divider.
package clint_pkg;

  localparam logic [15:0] MSIP_BASE     = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] MTIME_L       = 16'hBFF8;
  localparam logic [15:0] MTIME_H       = 16'hBFFC;

  localparam logic [63:0] MTIMECMP_RST  = '1;

  // max(1, clog2(div)); a divider of 1 or 2 still needs a 1-bit counter.
  function automatic int unsigned presc_width(input int unsigned div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/clint_hart_regs.sv
// clint_hart_regs: per-hart CLINT state.
//   clk, rst          : clock, synchronous active-high reset
//   mtimecmp_l_wen/h  : write reg_wdata into the low/high half of mtimecmp
//   msip_wen          : write reg_wdata[0] into msip
//   reg_wdata         : pre-merged 32-bit write word
//   mtime             : current global timer value
//   mtimecmp, msip    : register values for read-back
//   mtip              : registered timer interrupt (mtime >= mtimecmp)
module clint_hart_regs
  import clint_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mtimecmp_l_wen,
  input  logic        mtimecmp_h_wen,
  input  logic        msip_wen,
  input  logic [31:0] reg_wdata,
  input  logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        msip,
  output logic        mtip
);

  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp <= MTIMECMP_RST;
      msip     <= 1'b0;
      mtip     <= 1'b0;
    end else begin
      if (mtimecmp_l_wen) mtimecmp[31:0]  <= reg_wdata;
      if (mtimecmp_h_wen) mtimecmp[63:32] <= reg_wdata;
      if (msip_wen)       msip            <= reg_wdata[0];
      // Compares the current register values, so mtip trails any change
      // to mtime or mtimecmp by one cycle and is purely level-sensitive.
      mtip <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: rtl/clint_regs.sv
// clint_regs: CLINT register core.
//   clk, rst        : clock, synchronous active-high reset
//   mtime_l_wen/h   : write reg_wdata into mtime[31:0] / mtime[63:32]
//   mtimecmp_l_wen/h: per-hart write strobes for mtimecmp halves
//   msip_wen        : per-hart write strobe for msip (data bit 0)
//   reg_wdata       : pre-merged 32-bit write word
//   mtime           : 64-bit timer, increments once every TICK_DIV clocks
//   mtimecmp        : hart i at bits [64i+63:64i]
//   msip, mtip      : per-hart software / timer interrupt pending
module clint_regs
  import clint_pkg::*;
#(
  parameter int unsigned HART_NUM = 1,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mtime_l_wen,
  input  logic                     mtime_h_wen,
  input  logic [HART_NUM-1:0]      mtimecmp_l_wen,
  input  logic [HART_NUM-1:0]      mtimecmp_h_wen,
  input  logic [HART_NUM-1:0]      msip_wen,
  input  logic [31:0]              reg_wdata,
  output logic [63:0]              mtime,
  output logic [64*HART_NUM-1:0]   mtimecmp,
  output logic [HART_NUM-1:0]      msip,
  output logic [HART_NUM-1:0]      mtip
);

  localparam int unsigned     PW         = presc_width(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;

  // With TICK_DIV=1 the counter is pinned at 0 == PRESC_LAST, so tick is constant 1.
  assign tick = (presc == PRESC_LAST);

  // Free-running; mtime writes never disturb the tick phase.
  always_ff @(posedge clk) begin
    if (rst)       presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime <= '0;
    end else if (mtime_l_wen && mtime_h_wen) begin
      mtime <= {reg_wdata, reg_wdata};
    end else if (mtime_l_wen) begin
      // Low write wins over the tick; high half holds.
      mtime[31:0] <= reg_wdata;
    end else if (mtime_h_wen) begin
      // High write wins; carry out of the low half is dropped.
      mtime[63:32] <= reg_wdata;
      mtime[31:0]  <= mtime[31:0] + {31'd0, tick};
    end else begin
      mtime <= mtime + {63'd0, tick};
    end
  end

  for (genvar h = 0; h < HART_NUM; h++) begin : g_hart
    clint_hart_regs u_hart (
      .clk            (clk),
      .rst            (rst),
      .mtimecmp_l_wen (mtimecmp_l_wen[h]),
      .mtimecmp_h_wen (mtimecmp_h_wen[h]),
      .msip_wen       (msip_wen[h]),
      .reg_wdata      (reg_wdata),
      .mtime          (mtime),
      .mtimecmp       (mtimecmp[64*h +: 64]),
      .msip           (msip[h]),
      .mtip           (mtip[h])
    );
  end

endmodule

// File: tb/tb_clint_regs.sv
// tb_clint_regs: two clint_regs instances (TICK_DIV=1 and TICK_DIV=4, both
// with two harts) driven by the same directed strobes, checked every cycle
// against a behavioural model plus hand-computed literal values.
module tb_clint_regs;

  logic         clk;
  logic         rst;
  logic         mtime_l_wen, mtime_h_wen;
  logic [1:0]   mtimecmp_l_wen, mtimecmp_h_wen, msip_wen;
  logic [31:0]  reg_wdata;

  logic [63:0]  mtime1, mtime4;
  logic [127:0] cmp1, cmp4;
  logic [1:0]   msip1, msip4, mtip1, mtip4;

  int unsigned checks = 0;
  int unsigned errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  clint_regs #(.HART_NUM(2), .TICK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .mtime_l_wen(mtime_l_wen), .mtime_h_wen(mtime_h_wen),
    .mtimecmp_l_wen(mtimecmp_l_wen), .mtimecmp_h_wen(mtimecmp_h_wen),
    .msip_wen(msip_wen), .reg_wdata(reg_wdata),
    .mtime(mtime1), .mtimecmp(cmp1), .msip(msip1), .mtip(mtip1)
  );

  clint_regs #(.HART_NUM(2), .TICK_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .mtime_l_wen(mtime_l_wen), .mtime_h_wen(mtime_h_wen),
    .mtimecmp_l_wen(mtimecmp_l_wen), .mtimecmp_h_wen(mtimecmp_h_wen),
    .msip_wen(msip_wen), .reg_wdata(reg_wdata),
    .mtime(mtime4), .mtimecmp(cmp4), .msip(msip4), .mtip(mtip4)
  );

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Index 0 models the TICK_DIV=1 instance, index 1 the TICK_DIV=4 instance.
  logic [63:0] m_mtime [2];
  logic [63:0] m_cmp   [2][2];
  logic [1:0]  m_msip  [2];
  logic [1:0]  m_mtip  [2];
  int unsigned m_cnt   [2];   // clocks elapsed since reset release
  bit          model_valid = 1'b0;

  function automatic int unsigned div_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  // The n-th clock after reset (n counted from 0) carries a tick when n mod D == D-1.
  function automatic bit tick_of(input int k, input int unsigned n);
    return (n % div_of(k)) == (div_of(k) - 1);
  endfunction

  function automatic logic [63:0] next_mtime(input logic [63:0] cur, input bit t,
                                             input logic l, input logic h,
                                             input logic [31:0] w);
    logic [31:0] lo, hi;
    lo = cur[31:0];
    hi = cur[63:32];
    if (l && h) return {w, w};
    if (l)      return {hi, w};
    if (h)      return {w, lo + 32'(t)};
    return cur + 64'(t);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_mtime[k] <= '0;
        m_msip[k]  <= '0;
        m_mtip[k]  <= '0;
        m_cnt[k]   <= 0;
        for (int h = 0; h < 2; h++) m_cmp[k][h] <= '1;
      end else begin
        m_cnt[k]   <= m_cnt[k] + 1;
        m_mtime[k] <= next_mtime(m_mtime[k], tick_of(k, m_cnt[k]),
                                 mtime_l_wen, mtime_h_wen, reg_wdata);
        for (int h = 0; h < 2; h++) begin
          m_mtip[k][h] <= (m_mtime[k] >= m_cmp[k][h]);
          m_cmp[k][h]  <= {mtimecmp_h_wen[h] ? reg_wdata : m_cmp[k][h][63:32],
                           mtimecmp_l_wen[h] ? reg_wdata : m_cmp[k][h][31:0]};
          if (msip_wen[h]) m_msip[k][h] <= reg_wdata[0];
        end
      end
    end
    if (rst) model_valid <= 1'b1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_valid) begin
      chk64("mtime_d1", mtime1, m_mtime[0]);
      chk64("mtime_d4", mtime4, m_mtime[1]);
      for (int h = 0; h < 2; h++) begin
        chk64("mtimecmp_d1", cmp1[64*h +: 64], m_cmp[0][h]);
        chk64("mtimecmp_d4", cmp4[64*h +: 64], m_cmp[1][h]);
      end
      chk64("msip_d1", {62'd0, msip1}, {62'd0, m_msip[0]});
      chk64("msip_d4", {62'd0, msip4}, {62'd0, m_msip[1]});
      chk64("mtip_d1", {62'd0, mtip1}, {62'd0, m_mtip[0]});
      chk64("mtip_d4", {62'd0, mtip4}, {62'd0, m_mtip[1]});
    end
  end

  // ---------------- stimulus ----------------
  // Drive one cycle of inputs at a falling edge; returns at the next falling
  // edge, so outputs then reflect these inputs.
  task automatic cyc(input logic l, input logic h, input logic [1:0] cl,
                     input logic [1:0] ch, input logic [1:0] ms, input logic [31:0] w);
    mtime_l_wen    = l;
    mtime_h_wen    = h;
    mtimecmp_l_wen = cl;
    mtimecmp_h_wen = ch;
    msip_wen       = ms;
    reg_wdata      = w;
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk64({tag, "_mtime_d1"}, mtime1, 64'd0);
    chk64({tag, "_mtime_d4"}, mtime4, 64'd0);
    chk64({tag, "_cmp_d1_lo"}, cmp1[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
    chk64({tag, "_cmp_d1_hi"}, cmp1[127:64], 64'hFFFF_FFFF_FFFF_FFFF);
    chk64({tag, "_cmp_d4_lo"}, cmp4[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
    chk64({tag, "_msip"}, {60'd0, msip1, msip4}, 64'd0);
    chk64({tag, "_mtip"}, {60'd0, mtip1, mtip4}, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mtime_l_wen    = 1'($urandom);
      mtime_h_wen    = 1'($urandom);
      mtimecmp_l_wen = 2'($urandom);
      mtimecmp_h_wen = 2'($urandom);
      msip_wen       = 2'($urandom);
      reg_wdata      = $urandom;
      @(negedge clk);
    end
    chk_reset_state("reset");
    rst = 1'b0;

    // Prescaler and low-half carry
    idle(1);
    cyc(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 32'hFFFF_FFFE);
    cyc(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 32'd0);
    chk64("carry_pre_d4", mtime4, 64'h0000_0000_FFFF_FFFE);
    chk64("carry_pre_d1", mtime1, 64'h0000_0000_FFFF_FFFF);
    idle(5);
    chk64("carry_d4", mtime4, 64'h0000_0001_0000_0000);
    chk64("carry_d1", mtime1, 64'h0000_0001_0000_0004);

    // Write-vs-tick collisions (d1 ticks every clock)
    cyc(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 32'd0);
    cyc(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 32'hFFFF_FFFF);
    chk64("coll_setup_d1", mtime1, 64'h0000_0000_FFFF_FFFF);
    cyc(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 32'd7);
    chk64("coll_hwen_d1", mtime1, 64'h0000_0007_0000_0000);
    cyc(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 32'd3);
    chk64("coll_lwen_d1", mtime1, 64'h0000_0007_0000_0003);
    cyc(1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 32'h1234_5678);
    chk64("both_wen_d1", mtime1, 64'h1234_5678_1234_5678);
    chk64("both_wen_d4", mtime4, 64'h1234_5678_1234_5678);

    // 64-bit wrap with hart 1 compare at 5
    cyc(1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 32'd0);
    cyc(1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 32'd5);
    chk64("cmp1_d1", cmp1[127:64], 64'd5);
    chk64("cmp1_d4", cmp4[127:64], 64'd5);
    cyc(1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 32'hFFFF_FFFF);
    chk64("wrap_load_d1", mtime1, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(1);
    chk64("wrap_d1", mtime1, 64'd0);
    chk64("wrap_mtip_hi_d1", {63'd0, mtip1[1]}, 64'd1);
    idle(1);
    chk64("wrap_mtip_lo_d1", {63'd0, mtip1[1]}, 64'd0);
    chk64("wrap_next_d1", mtime1, 64'd1);

    // Timer interrupt on hart 0
    cyc(1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 32'd0);
    cyc(1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 32'd10);
    cyc(1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 32'd0);
    idle(10);
    chk64("tmr_at10_mtime", mtime1, 64'd10);
    chk64("tmr_at10_mtip", {63'd0, mtip1[0]}, 64'd0);
    idle(1);
    chk64("tmr_rise_mtip", {63'd0, mtip1[0]}, 64'd1);
    cyc(1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 32'd1);
    chk64("tmr_cmp_raised", cmp1[63:0], 64'h0000_0001_0000_000A);
    chk64("tmr_still_set", {63'd0, mtip1[0]}, 64'd1);
    idle(1);
    chk64("tmr_fall_mtip", {63'd0, mtip1[0]}, 64'd0);

    // Multi-hart msip
    cyc(1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 32'd1);
    chk64("msip_set", {60'd0, msip1, msip4}, 64'hF);
    cyc(1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 32'hFFFF_FFFE);
    chk64("msip_clr", {60'd0, msip1, msip4}, 64'h0);
    cyc(1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 32'd1);
    chk64("msip_h1", {60'd0, msip1, msip4}, 64'hA);

    // Reset mid-operation overrides all strobes
    rst = 1'b1;
    cyc(1'b1, 1'b1, 2'b11, 2'b11, 2'b11, 32'hFFFF_FFFF);
    chk_reset_state("midreset");
    rst = 1'b0;
    idle(9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clint_regs.md
# clint_regs

CLINT register core: holds the 64-bit `mtime` counter, per-hart `mtimecmp` and `msip` registers, and generates per-hart machine timer and software interrupt lines. It sits directly downstream of `clint_axi2reg`, which decodes AXI writes into one-cycle write-enable strobes plus a pre-merged 32-bit write word, and reads back the register values this block exports. Interrupt outputs go to each hart's CSR/interrupt logic.

## Interface
Parameters:
- `HART_NUM`, 1: number of harts; sets the `mtimecmp` and `msip` replication count.
- `TICK_DIV`, 1: `mtime` increments once every `TICK_DIV` clocks. Legal range is 1..65536.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: synchronous, active-high reset.
- `mtime_l_wen`, input, 1: write `reg_wdata` to `mtime[31:0]`.
- `mtime_h_wen`, input, 1: write `reg_wdata` to `mtime[63:32]`.
- `mtimecmp_l_wen`, input, HART_NUM: per-hart write to `mtimecmp[i][31:0]`.
- `mtimecmp_h_wen`, input, HART_NUM: per-hart write to `mtimecmp[i][63:32]`.
- `msip_wen`, input, HART_NUM: per-hart write of `reg_wdata[0]` to `msip[i]`.
- `reg_wdata`, input, 32: write data, already byte-merged by the producer.
- `mtime`, output, 64: current counter value.
- `mtimecmp`, output, 64*HART_NUM: hart i occupies bits [64i+63:64i].
- `msip`, output, HART_NUM: software interrupt pending, one bit per hart.
- `mtip`, output, HART_NUM: timer interrupt pending, registered, one bit per hart.

## Operation
Reset values:
- `mtime` = 0.
- Every `mtimecmp[i]` = 64'hFFFF_FFFF_FFFF_FFFF, so no interrupt fires after reset.
- `msip` = 0, `mtip` = 0.
- Prescaler = 0.

Prescaler:
- Free-running counter from 0 to TICK_DIV-1, then back to 0.
- `tick` is asserted in the cycle the prescaler equals TICK_DIV-1.
- With TICK_DIV=1, `tick` is always 1.
- Counter width is max(1, clog2(TICK_DIV)).
- Writes to `mtime` do not reset or stall the prescaler.

`mtime` update, per cycle, in priority order:
- **`mtime_l_wen`:** low half = `reg_wdata`. High half holds, unless `mtime_h_wen` is also set. Any tick in this cycle is dropped.
- **`mtime_h_wen` only:** high half = `reg_wdata`. Low half increments if `tick`. Any carry out of the low half is discarded, because the write wins.
- **Both strobes set:** full 64-bit load of {`reg_wdata`, `reg_wdata`}. The producer never issues this; it is defined for robustness only.
- **No write:** `mtime` = `mtime` + `tick`, as a 64-bit add. 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.

`mtimecmp`:
- Each half loads `reg_wdata` on its strobe; otherwise it holds.
- Low and high writes to the same hart in one cycle are both applied.

`msip`:
- `msip[i]` loads `reg_wdata[0]` on `msip_wen[i]`.
- Bits [31:1] of the write are ignored.

`mtip`:
- `mtip[i]` <= (`mtime` >= `mtimecmp[i]`), an unsigned 64-bit compare of the current register values.
- It is recomputed every cycle, so it is level-sensitive and clears as soon as software raises `mtimecmp`.

Other rules:
- Multiple strobes for different harts in the same cycle are all applied.
- Reset asserted mid-operation overrides all strobes and ticks that cycle.

## Timing
- All register outputs change only at the rising edge of `clk`.
- Write latency: a strobe sampled at edge N makes the new value visible on `mtime`, `mtimecmp` or `msip` immediately after edge N.
- `mtip` latency is one cycle after the register change: a write at edge N is reflected on `mtip` after edge N+1.
- The same one-cycle rule applies to `mtime` crossing `mtimecmp`.
- Increment rate: with TICK_DIV=D, the first increment after reset occurs at edge D, then every D edges.
- No combinational path from any input to any output.

## Structure
- Shared package/header `clint_pkg`:
  - Address offset constants MSIP_BASE=16'h0000, MTIMECMP_BASE=16'h4000, MTIME_L=16'hBFF8, MTIME_H=16'hBFFC, also used by `clint_axi2reg`.
  - MTIMECMP_RST=64'hFFFF_FFFF_FFFF_FFFF.
- One natural sub-module, `clint_hart_regs`, instantiated HART_NUM times:
  - Holds `mtimecmp`, `msip` and the `mtip` comparator/register for one hart.
  - Takes `mtime` as an input.
- The prescaler and `mtime` counter stay in the top level.

## Test plan
- **Reset:** hold `rst` 3 cycles with random strobes active -> `mtime`=0, `mtimecmp`=all-ones, `msip`=0, `mtip`=0.
- **Prescaler and low-half carry:** TICK_DIV=4; write `mtime_l`=32'hFFFF_FFFE, `mtime_h`=0 -> `mtime` reaches 64'h0000_0001_0000_0000 after 8 clocks, and advances exactly every 4th clock.
- **64-bit wrap:** `mtime` = all-ones at a tick with no write -> next value 0; `mtip` for a hart with `mtimecmp`=5 deasserts one cycle later.
- **Timer interrupt:**
  - Set `mtimecmp[0]` to 64'd10, TICK_DIV=1 -> `mtip[0]` rises exactly one cycle after `mtime` becomes 10.
  - Then write `mtimecmp_h[0]`=1 -> `mtip[0]` falls one cycle after the write.
- **Write-vs-tick collisions:**
  - `mtime`=64'h0000_0000_FFFF_FFFF with tick and `mtime_h_wen` writing 7 -> 64'h0000_0007_0000_0000.
  - Tick with `mtime_l_wen` writing 3 -> low=3, high unchanged.
- **Multi-hart `msip`:** HART_NUM=2; `msip_wen`=2'b11 with `reg_wdata`=32'hFFFF_FFFE -> `msip`=2'b00; then `reg_wdata`=1 with `msip_wen`=2'b10 -> `msip`=2'b10.
